// File: rtl/arbitrated_memory_interface_if.sv
// ============================================================================
// Module      : arbitrated_memory_interface_if
// Description : Cache-port and main-memory bus bundle for the arbitrated
//               memory interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbitrated_memory_interface_if #(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NUM_PORTS     = 2
);
    localparam int BUS_WIDTH = DATA_WIDTH * (1 << OFFSET_BITS);

    logic [NUM_PORTS*MSG_BITS-1:0]      cache2interface_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2interface_address;
    logic [NUM_PORTS*BUS_WIDTH-1:0]     cache2interface_data;
    logic [NUM_PORTS*MSG_BITS-1:0]      interface2cache_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] interface2cache_address;
    logic [BUS_WIDTH-1:0]               interface2cache_data;
    logic [MSG_BITS-1:0]                mem2interface_msg;
    logic [ADDRESS_WIDTH-1:0]           mem2interface_address;
    logic [DATA_WIDTH-1:0]              mem2interface_data;
    logic [MSG_BITS-1:0]                interface2mem_msg;
    logic [ADDRESS_WIDTH-1:0]           interface2mem_address;
    logic [DATA_WIDTH-1:0]              interface2mem_data;
    logic                               busy;

    modport slave (
        input  cache2interface_msg, cache2interface_address, cache2interface_data,
        input  mem2interface_msg, mem2interface_address, mem2interface_data,
        output interface2cache_msg, interface2cache_address, interface2cache_data,
        output interface2mem_msg, interface2mem_address, interface2mem_data,
        output busy
    );

    modport master (
        output cache2interface_msg, cache2interface_address, cache2interface_data,
        output mem2interface_msg, mem2interface_address, mem2interface_data,
        input  interface2cache_msg, interface2cache_address, interface2cache_data,
        input  interface2mem_msg, interface2mem_address, interface2mem_data,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/arbitrated_memory_interface.sv
// ============================================================================
// Module      : arbitrated_memory_interface
// Description : Round-robin arbiter that serialises cache-line reads and
//               writebacks from NUM_PORTS cache ports into word transactions
//               on main memory. Optional MMI_CRITICAL_WORD_FIRST_EN starts
//               reads at the requested word and wraps within the line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitrated_memory_interface #(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NUM_PORTS     = 2,
    parameter logic [MSG_BITS-1:0] NO_REQ   = 4'd0,
    parameter logic [MSG_BITS-1:0] WB_REQ   = 4'd1,
    parameter logic [MSG_BITS-1:0] R_REQ    = 4'd2,
    parameter logic [MSG_BITS-1:0] FLUSH    = 4'd3,
    parameter logic [MSG_BITS-1:0] MEM_RESP = 4'd4
) (
    input wire logic                    clock,
    input wire logic                    reset,
    arbitrated_memory_interface_if.slave bus
);
    localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;
    localparam int BUS_WIDTH      = DATA_WIDTH * WORDS_PER_LINE;
    localparam int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PORT_BITS-1:0]   LAST_PORT = PORT_BITS'(NUM_PORTS - 1);
    localparam logic [OFFSET_BITS:0]   LAST_WORD = (OFFSET_BITS + 1)'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_MEMORY  = 2'd1,
        WRITE_MEMORY = 2'd2,
        RESPOND      = 2'd3
    } state_t;

    state_t                             r_state;
    logic [PORT_BITS-1:0]               r_last_grant;
    logic [PORT_BITS-1:0]               r_grant;
    logic [ADDRESS_WIDTH-1:0]           r_req_addr;
    logic [BUS_WIDTH-1:0]               r_line;
    logic [OFFSET_BITS:0]               r_count;
    logic [OFFSET_BITS-1:0]             r_offset;
    logic [NUM_PORTS*MSG_BITS-1:0]      r_cache_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] r_cache_addr;
    logic [MSG_BITS-1:0]                r_mem_msg;
    logic [ADDRESS_WIDTH-1:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0]              r_mem_data;
    logic                               r_busy;

    logic                               w_found;
    logic [PORT_BITS-1:0]               w_sel;
    logic [MSG_BITS-1:0]                w_sel_msg;
    logic [ADDRESS_WIDTH-1:0]           w_sel_addr;
    logic [BUS_WIDTH-1:0]               w_sel_line;
    logic [OFFSET_BITS-1:0]             w_read_start;
    logic [OFFSET_BITS-1:0]             w_slot;
    logic [OFFSET_BITS-1:0]             w_next_slot;
    logic                               w_last;

    function automatic logic is_request(input logic [MSG_BITS-1:0] msg);
        return (msg == R_REQ) || (msg == WB_REQ) || (msg == FLUSH);
    endfunction

    // Scan starts one past the previous winner so every port is reached within NUM_PORTS grants.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!w_found && is_request(bus.cache2interface_msg[((int'(r_last_grant) + i) % NUM_PORTS)*MSG_BITS +: MSG_BITS])) begin
                w_found = 1'b1;
                w_sel   = PORT_BITS'((int'(r_last_grant) + i) % NUM_PORTS);
            end
        end
    end

    assign w_sel_msg  = bus.cache2interface_msg[int'(w_sel)*MSG_BITS +: MSG_BITS];
    assign w_sel_addr = bus.cache2interface_address[int'(w_sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_sel_line = bus.cache2interface_data[int'(w_sel)*BUS_WIDTH +: BUS_WIDTH];

`ifdef MMI_CRITICAL_WORD_FIRST_EN
    assign w_read_start = w_sel_addr[OFFSET_BITS-1:0];
`else
    assign w_read_start = '0;
`endif

    // Slot index wraps naturally in OFFSET_BITS, giving the modulo-line walk.
    assign w_slot      = r_offset + r_count[OFFSET_BITS-1:0];
    assign w_next_slot = w_slot + OFFSET_BITS'(1);
    assign w_last      = (r_count == LAST_WORD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= LAST_PORT;
            r_grant      <= '0;
            r_req_addr   <= '0;
            r_line       <= '0;
            r_count      <= '0;
            r_offset     <= '0;
            r_cache_msg  <= {NUM_PORTS{NO_REQ}};
            r_cache_addr <= '0;
            r_mem_msg    <= NO_REQ;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_req_addr   <= w_sel_addr;
                        r_count      <= '0;
                        r_busy       <= 1'b1;
                        if (w_sel_msg == R_REQ) begin
                            r_state    <= READ_MEMORY;
                            r_offset   <= w_read_start;
                            r_mem_msg  <= R_REQ;
                            r_mem_addr <= {w_sel_addr[ADDRESS_WIDTH-1:OFFSET_BITS], w_read_start};
                            r_mem_data <= '0;
                        end else begin
                            r_state    <= WRITE_MEMORY;
                            r_line     <= w_sel_line;
                            r_offset   <= '0;
                            r_mem_msg  <= WB_REQ;
                            r_mem_addr <= {w_sel_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                            r_mem_data <= w_sel_line[DATA_WIDTH-1:0];
                        end
                    end
                end
                READ_MEMORY: begin
                    if (bus.mem2interface_msg == MEM_RESP) begin
                        r_line[int'(w_slot)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem2interface_data;
                        r_count <= r_count + (OFFSET_BITS + 1)'(1);
                        if (w_last) begin
                            r_state    <= RESPOND;
                            r_mem_msg  <= NO_REQ;
                            r_mem_addr <= '0;
                            r_mem_data <= '0;
                            r_cache_msg[int'(r_grant)*MSG_BITS +: MSG_BITS]           <= MEM_RESP;
                            r_cache_addr[int'(r_grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= r_req_addr;
                        end else begin
                            r_mem_addr <= {r_req_addr[ADDRESS_WIDTH-1:OFFSET_BITS], w_next_slot};
                        end
                    end
                end
                WRITE_MEMORY: begin
                    if (bus.mem2interface_msg == MEM_RESP) begin
                        r_count <= r_count + (OFFSET_BITS + 1)'(1);
                        if (w_last) begin
                            r_state    <= RESPOND;
                            r_mem_msg  <= NO_REQ;
                            r_mem_addr <= '0;
                            r_mem_data <= '0;
                            r_cache_msg[int'(r_grant)*MSG_BITS +: MSG_BITS]           <= MEM_RESP;
                            r_cache_addr[int'(r_grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= r_req_addr;
                        end else begin
                            r_mem_addr <= {r_req_addr[ADDRESS_WIDTH-1:OFFSET_BITS], w_next_slot};
                            r_mem_data <= r_line[int'(w_next_slot)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                RESPOND: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_cache_msg  <= {NUM_PORTS{NO_REQ}};
                    r_cache_addr <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.interface2cache_msg     = r_cache_msg;
    assign bus.interface2cache_address = r_cache_addr;
    assign bus.interface2cache_data    = r_line;
    assign bus.interface2mem_msg       = r_mem_msg;
    assign bus.interface2mem_address   = r_mem_addr;
    assign bus.interface2mem_data      = r_mem_data;
    assign bus.busy                    = r_busy;

endmodule

`default_nettype wire
